blackjack_round_ctrl: RTL and testbench
=======================================

// Module: blackjack_round_ctrl
// PURPOSE
//  Round sequencer for the blackjack game: owns the draw_card unit, deciding when it draws and for whom (turn).
//  Runs the initial deal, then player hit/stand, then dealer auto-draw, and accumulates both hand totals.
//  Sits between the debounced KEY/SW inputs and draw_card; sums and result feed the HEX/LEDR display logic.
// PARAMETERS
//  INIT_CARDS    2   cards dealt to each side before player decisions, alternating P,D,P,D
//  DEALER_STAND  17  dealer draws while dealer_sum < DEALER_STAND
//  BUST_LIMIT    21  hand total above this is bust
//  SUM_W         5   width of hand-total registers
// PORTS
//  clock       in   1      system clock (CLOCK_50 or rateDivider output)
//  resetn      in   1      asynchronous, active-low reset
//  start       in   1      one-cycle pulse: begin new round (IDLE or RESULT only)
//  hit         in   1      one-cycle pulse: player requests a card (PLAYER state only)
//  stand       in   1      one-cycle pulse: player ends turn (PLAYER state only)
//  card_in     in   4      card value from draw_card; legal 1..10
//  draw_req    out  1      drives draw_card.in; high exactly one cycle per draw
//  turn        out  1      drives draw_card.turn; 0 = player, 1 = dealer
//  player_sum  out  SUM_W  player hand total
//  dealer_sum  out  SUM_W  dealer hand total
//  result      out  2      00 none, 01 player wins, 10 dealer wins, 11 push
//  busy        out  1      high in every state except IDLE and RESULT
//  card_err    out  1      sticky; set when sampled card_in is 0 or >10
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE; draw_req, turn, sums, result, busy, card_err all 0; deal counter 0.
//  States: IDLE, DEAL_REQ, DEAL_WAIT, PLAYER, P_REQ, P_WAIT, DEALER, D_REQ, D_WAIT, RESULT.
//  Draw handshake: *_REQ asserts draw_req for 1 cycle with turn valid; *_WAIT samples card_in next cycle
//   (latency 1); turn held constant across REQ and WAIT.
//  IDLE/RESULT --start--> DEAL_REQ; sums, result, card_err, deal counter cleared on that edge.
//  DEAL_REQ/DEAL_WAIT loop 2*INIT_CARDS times; turn = deal counter[0] (even -> player, odd -> dealer).
//  After last deal card -> PLAYER. If player_sum > BUST_LIMIT here or after any hit -> RESULT, result=10.
//  PLAYER: hit -> P_REQ; stand -> DEALER; hit and stand same cycle: stand wins; neither: hold.
//  P_WAIT: add card, -> PLAYER (or RESULT on bust).
//  DEALER: dealer_sum < DEALER_STAND -> D_REQ, else compare -> RESULT.
//  D_WAIT: add card, -> DEALER. Dealer bust (> BUST_LIMIT) -> RESULT, result=01.
//  Compare: player>dealer 01; dealer>player 10; equal 11.
//  Arithmetic: sum <= sum + card, saturating at 2^SUM_W-1 (31); never wraps.
//  Illegal card (0 or >10): set card_err, add nothing, re-issue the same draw (return to that REQ state).
//  start while busy ignored; hit/stand outside PLAYER ignored; result only nonzero in RESULT.
//  resetn low mid-draw: draw_req drops immediately, pending card discarded.
// CONFIGURATION
//  ACE_HIGH_EN defined: card_in==1 counts 11 when sum+11 <= BUST_LIMIT, tracked per hand as a soft ace;
//   if later total exceeds BUST_LIMIT with a soft ace, subtract 10 once and clear soft flag (same cycle).
//   Dealer stands on soft DEALER_STAND.
//  ACE_HIGH_EN undefined: ace always counts 1; no soft-ace registers synthesized.
// TESTING
//  Card stub feeds fixed sequence one cycle after draw_req; check draw_req is single-cycle each time.
//  Deal 10,9,7,8 then stand -> player 17, dealer 17, result=11; draw_req pulses exactly 4 times, turn 0,1,0,1.
//  Deal 10,10,6,7 then hit with card 9 -> player 25, result=10, no dealer draws, busy falls.
//  Deal 10,6,8,5, stand; dealer gets 4 then 9 -> dealer 24, result=01; 2 dealer draws, turn=1 on both.
//  In PLAYER assert hit and stand same cycle -> no draw_req, state goes to DEALER.
//  card_in=0 on first deal -> card_err=1, same draw re-issued, sums unchanged; then normal completion.
//  Pull resetn low during D_WAIT -> all outputs 0 asynchronously; start after release begins clean round.
//  ACE_HIGH_EN: deal 1,10,5,7 -> player_sum 16 (soft); hit 9 -> player_sum 15 (hard), not bust.

Source files
------------

// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencer: initial deal, player hit/stand, dealer auto-draw, result.
// Optional macro ACE_HIGH_EN enables soft-ace (ace = 11) scoring.
module blackjack_round_ctrl #(
  parameter int INIT_CARDS   = 2,
  parameter int DEALER_STAND = 17,
  parameter int BUST_LIMIT   = 21,
  parameter int SUM_W        = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             hit,
  input  logic             stand,
  input  logic [3:0]       card_in,
  output logic             draw_req,
  output logic             turn,
  output logic [SUM_W-1:0] player_sum,
  output logic [SUM_W-1:0] dealer_sum,
  output logic [1:0]       result,
  output logic             busy,
  output logic             card_err
);

  localparam int DCW = $clog2(2*INIT_CARDS + 1);
  localparam logic [DCW-1:0]   DEAL_LAST = DCW'(2*INIT_CARDS - 1);
  localparam logic [SUM_W-1:0] BUST      = SUM_W'(BUST_LIMIT);
  localparam logic [SUM_W-1:0] STAND_AT  = SUM_W'(DEALER_STAND);

  typedef enum logic [3:0] {
    IDLE, DEAL_REQ, DEAL_WAIT, PLAYER, P_REQ, P_WAIT, DEALER, D_REQ, D_WAIT, RESULT
  } state_t;

  state_t           state, state_n;
  logic [1:0]       res_n;
  logic [DCW-1:0]   deal_cnt;
  logic [SUM_W-1:0] p_new, d_new;
  logic             card_ok, clr, p_load, d_load, err_set;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [3:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W-3){1'b0}}, b};
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction

  assign card_ok = (card_in != 4'd0) && (card_in <= 4'd10);
  assign clr     = start && (state == IDLE || state == RESULT);
  assign p_load  = card_ok && ((state == DEAL_WAIT && !deal_cnt[0]) || state == P_WAIT);
  assign d_load  = card_ok && ((state == DEAL_WAIT && deal_cnt[0]) || state == D_WAIT);
  assign err_set = !card_ok && (state == DEAL_WAIT || state == P_WAIT || state == D_WAIT);

`ifdef ACE_HIGH_EN
  localparam logic [SUM_W-1:0] ACE_MAX = SUM_W'(BUST_LIMIT - 11);
  logic p_soft, d_soft, p_soft_new, d_soft_new;

  // Returns {soft_flag, total}; a soft ace is demoted once when the hand would bust.
  function automatic logic [SUM_W:0] add_card(input logic [SUM_W-1:0] sum, input logic soft,
                                              input logic [3:0] card);
    logic [SUM_W-1:0] tot;
    logic             ace_hi, s;
    ace_hi = (card == 4'd1) && (sum <= ACE_MAX);
    tot    = sat_add(sum, ace_hi ? 4'd11 : card);
    s      = soft | ace_hi;
    if (tot > BUST && s) begin
      tot = tot - SUM_W'(10);
      s   = 1'b0;
    end
    return {s, tot};
  endfunction

  always_comb begin
    {p_soft_new, p_new} = add_card(player_sum, p_soft, card_in);
    {d_soft_new, d_new} = add_card(dealer_sum, d_soft, card_in);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      p_soft <= 1'b0;
      d_soft <= 1'b0;
    end else if (clr) begin
      p_soft <= 1'b0;
      d_soft <= 1'b0;
    end else begin
      if (p_load) p_soft <= p_soft_new;
      if (d_load) d_soft <= d_soft_new;
    end
  end
`else
  assign p_new = sat_add(player_sum, card_in);
  assign d_new = sat_add(dealer_sum, card_in);
`endif

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state and result decision
  always_comb begin
    state_n = state;
    res_n   = 2'b00;
    unique case (state)
      IDLE, RESULT: if (start) state_n = DEAL_REQ;
      DEAL_REQ:     state_n = DEAL_WAIT;
      DEAL_WAIT: begin
        if (!card_ok)                   state_n = DEAL_REQ;
        else if (deal_cnt != DEAL_LAST) state_n = DEAL_REQ;
        else if ((deal_cnt[0] ? player_sum : p_new) > BUST) begin
          state_n = RESULT;
          res_n   = 2'b10;
        end else                        state_n = PLAYER;
      end
      PLAYER: begin
        if (stand)    state_n = DEALER;
        else if (hit) state_n = P_REQ;
      end
      P_REQ:        state_n = P_WAIT;
      P_WAIT: begin
        if (!card_ok)          state_n = P_REQ;
        else if (p_new > BUST) begin
          state_n = RESULT;
          res_n   = 2'b10;
        end else               state_n = PLAYER;
      end
      DEALER: begin
        if (dealer_sum < STAND_AT) state_n = D_REQ;
        else begin
          state_n = RESULT;
          if (player_sum > dealer_sum)      res_n = 2'b01;
          else if (dealer_sum > player_sum) res_n = 2'b10;
          else                              res_n = 2'b11;
        end
      end
      D_REQ:        state_n = D_WAIT;
      D_WAIT: begin
        if (!card_ok)          state_n = D_REQ;
        else if (d_new > BUST) begin
          state_n = RESULT;
          res_n   = 2'b01;
        end else               state_n = DEALER;
      end
      default:      state_n = IDLE;
    endcase
  end

  // Outputs decoded from state; turn is stable across each REQ/WAIT pair
  always_comb begin
    draw_req = 1'b0;
    turn     = 1'b0;
    busy     = 1'b1;
    unique case (state)
      IDLE, RESULT:  busy = 1'b0;
      DEAL_REQ: begin
        draw_req = 1'b1;
        turn     = deal_cnt[0];
      end
      DEAL_WAIT:     turn = deal_cnt[0];
      P_REQ:         draw_req = 1'b1;
      D_REQ: begin
        draw_req = 1'b1;
        turn     = 1'b1;
      end
      D_WAIT:        turn = 1'b1;
      default:       ;
    endcase
  end

  // Hand totals, deal counter, result and error flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      player_sum <= '0;
      dealer_sum <= '0;
      deal_cnt   <= '0;
      result     <= 2'b00;
      card_err   <= 1'b0;
    end else if (clr) begin
      player_sum <= '0;
      dealer_sum <= '0;
      deal_cnt   <= '0;
      result     <= 2'b00;
      card_err   <= 1'b0;
    end else begin
      if (p_load)  player_sum <= p_new;
      if (d_load)  dealer_sum <= d_new;
      if (err_set) card_err   <= 1'b1;
      if (card_ok && state == DEAL_WAIT) deal_cnt <= deal_cnt + 1'b1;
      if (state_n == RESULT && state != RESULT) result <= res_n;
    end
  end

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Scoreboard bench for blackjack_round_ctrl with a one-cycle-latency card stub.
module tb_blackjack_round_ctrl;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0, hit = 1'b0, stand = 1'b0;
  logic [3:0] card_in = 4'd0;
  logic       draw_req, turn, busy, card_err;
  logic [4:0] player_sum, dealer_sum;
  logic [1:0] result;

  blackjack_round_ctrl dut (
    .clock(clock), .resetn(resetn), .start(start), .hit(hit), .stand(stand),
    .card_in(card_in), .draw_req(draw_req), .turn(turn), .player_sum(player_sum),
    .dealer_sum(dealer_sum), .result(result), .busy(busy), .card_err(card_err)
  );

  always #5 clock = ~clock;

  typedef struct { logic [4:0] p; logic [4:0] d; logic [1:0] r; } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;

  // Card stub: tasks fill card_mem, the stub alone consumes it and logs draws
  logic [3:0] card_mem [0:63];
  int         wr = 0, rd = 0, draw_cnt = 0, dbl = 0;
  logic       obs_turn [0:255];
  logic       prev_req = 1'b0;

  always @(negedge clock) begin
    if (draw_req) begin
      if (prev_req) dbl = dbl + 1;
      obs_turn[draw_cnt] = turn;
      draw_cnt = draw_cnt + 1;
      if (rd < wr) begin
        card_in = card_mem[rd];
        rd = rd + 1;
      end else card_in = 4'd5;
    end
    prev_req = draw_req;
  end

  task automatic load(input logic [3:0] c);
    card_mem[wr] = c;
    wr = wr + 1;
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic press(input logic h, input logic s);
    @(negedge clock) begin hit = h; stand = s; end
    @(negedge clock) begin hit = 1'b0; stand = 1'b0; end
  endtask

  task automatic wait_draws(input int target);
    int n;
    n = 0;
    while (draw_cnt < target && n < 200) begin
      @(posedge clock) #2;
      n++;
    end
    if (draw_cnt < target) begin
      checks++; errors++;
      $display("FAIL wait_draws: got %0d draws, required %0d", draw_cnt, target);
    end
  endtask

  task automatic settle_player(input int target);
    wait_draws(target);
    repeat (2) @(posedge clock);
    #2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clock) #2;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    #1;
    checks += 7;
    if (draw_req   !== 1'b0)  begin errors++; $display("FAIL reset_draw_req: %b vs 0", draw_req); end
    if (turn       !== 1'b0)  begin errors++; $display("FAIL reset_turn: %b vs 0", turn); end
    if (player_sum !== 5'd0)  begin errors++; $display("FAIL reset_player_sum: %0d vs 0", player_sum); end
    if (dealer_sum !== 5'd0)  begin errors++; $display("FAIL reset_dealer_sum: %0d vs 0", dealer_sum); end
    if (result     !== 2'b00) begin errors++; $display("FAIL reset_result: %b vs 00", result); end
    if (busy       !== 1'b0)  begin errors++; $display("FAIL reset_busy: %b vs 0", busy); end
    if (card_err   !== 1'b0)  begin errors++; $display("FAIL reset_card_err: %b vs 0", card_err); end
    @(negedge clock) resetn = 1'b1;
  endtask

  task automatic test_push();
    int   base;
    exp_t e;
    logic t_exp [4];
    t_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
    base = draw_cnt;
    load(10); load(9); load(7); load(8);
    exp_q.push_back('{5'd17, 5'd17, 2'b11});
    pulse_start();
    settle_player(base + 4);
    press(1'b0, 1'b1);
    wait_idle();
    e = exp_q.pop_front();
    checks += 5;
    if (player_sum !== e.p) begin errors++; $display("FAIL push_player: %0d vs %0d", player_sum, e.p); end
    if (dealer_sum !== e.d) begin errors++; $display("FAIL push_dealer: %0d vs %0d", dealer_sum, e.d); end
    if (result     !== e.r) begin errors++; $display("FAIL push_result: %b vs %b", result, e.r); end
    if (draw_cnt - base != 4) begin errors++; $display("FAIL push_draws: %0d vs 4", draw_cnt - base); end
    if (card_err !== 1'b0) begin errors++; $display("FAIL push_card_err: %b vs 0", card_err); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_turn[base+i] !== t_exp[i]) begin
        errors++; $display("FAIL push_turn%0d: %b vs %b", i, obs_turn[base+i], t_exp[i]);
      end
    end
  endtask

  task automatic test_player_bust();
    int   base;
    exp_t e;
    base = draw_cnt;
    load(10); load(10); load(6); load(7); load(9);
    exp_q.push_back('{5'd25, 5'd17, 2'b10});
    pulse_start();
    settle_player(base + 4);
    press(1'b1, 1'b0);
    wait_idle();
    e = exp_q.pop_front();
    checks += 5;
    if (player_sum !== e.p) begin errors++; $display("FAIL pbust_player: %0d vs %0d", player_sum, e.p); end
    if (dealer_sum !== e.d) begin errors++; $display("FAIL pbust_dealer: %0d vs %0d", dealer_sum, e.d); end
    if (result     !== e.r) begin errors++; $display("FAIL pbust_result: %b vs %b", result, e.r); end
    if (draw_cnt - base != 5) begin errors++; $display("FAIL pbust_draws: %0d vs 5", draw_cnt - base); end
    if (obs_turn[base+4] !== 1'b0) begin errors++; $display("FAIL pbust_hit_turn: %b vs 0", obs_turn[base+4]); end
  endtask

  task automatic test_dealer_bust();
    int   base;
    exp_t e;
    base = draw_cnt;
    load(10); load(6); load(8); load(5); load(4); load(9);
    exp_q.push_back('{5'd18, 5'd24, 2'b01});
    pulse_start();
    settle_player(base + 4);
    press(1'b0, 1'b1);
    wait_idle();
    e = exp_q.pop_front();
    checks += 6;
    if (player_sum !== e.p) begin errors++; $display("FAIL dbust_player: %0d vs %0d", player_sum, e.p); end
    if (dealer_sum !== e.d) begin errors++; $display("FAIL dbust_dealer: %0d vs %0d", dealer_sum, e.d); end
    if (result     !== e.r) begin errors++; $display("FAIL dbust_result: %b vs %b", result, e.r); end
    if (draw_cnt - base != 6) begin errors++; $display("FAIL dbust_draws: %0d vs 6", draw_cnt - base); end
    if (obs_turn[base+4] !== 1'b1) begin errors++; $display("FAIL dbust_turn4: %b vs 1", obs_turn[base+4]); end
    if (obs_turn[base+5] !== 1'b1) begin errors++; $display("FAIL dbust_turn5: %b vs 1", obs_turn[base+5]); end
  endtask

  task automatic test_hit_and_stand();
    int   base;
    exp_t e;
    base = draw_cnt;
    load(10); load(10); load(5); load(7);
    exp_q.push_back('{5'd15, 5'd17, 2'b10});
    pulse_start();
    settle_player(base + 4);
    press(1'b1, 1'b1);
    wait_idle();
    e = exp_q.pop_front();
    checks += 3;
    if (player_sum !== e.p) begin errors++; $display("FAIL hs_player: %0d vs %0d", player_sum, e.p); end
    if (result     !== e.r) begin errors++; $display("FAIL hs_result: %b vs %b", result, e.r); end
    if (draw_cnt - base != 4) begin errors++; $display("FAIL hs_draws: %0d vs 4", draw_cnt - base); end
  endtask

  task automatic test_card_err();
    int   base;
    exp_t e;
    logic t_exp [5];
    t_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    base = draw_cnt;
    load(0); load(10); load(9); load(7); load(8);
    exp_q.push_back('{5'd17, 5'd17, 2'b11});
    pulse_start();
    wait_draws(base + 1);
    @(posedge clock) #2;
    checks += 2;
    if (card_err !== 1'b1)   begin errors++; $display("FAIL err_flag: %b vs 1", card_err); end
    if (player_sum !== 5'd0) begin errors++; $display("FAIL err_sum: %0d vs 0", player_sum); end
    settle_player(base + 5);
    press(1'b0, 1'b1);
    wait_idle();
    e = exp_q.pop_front();
    checks += 4;
    if (player_sum !== e.p) begin errors++; $display("FAIL err_player: %0d vs %0d", player_sum, e.p); end
    if (dealer_sum !== e.d) begin errors++; $display("FAIL err_dealer: %0d vs %0d", dealer_sum, e.d); end
    if (result     !== e.r) begin errors++; $display("FAIL err_result: %b vs %b", result, e.r); end
    if (card_err !== 1'b1)  begin errors++; $display("FAIL err_sticky: %b vs 1", card_err); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_turn[base+i] !== t_exp[i]) begin
        errors++; $display("FAIL err_turn%0d: %b vs %b", i, obs_turn[base+i], t_exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_draw();
    int   base;
    exp_t e;
    base = draw_cnt;
    load(10); load(6); load(8); load(5); load(4); load(9);
    pulse_start();
    settle_player(base + 4);
    press(1'b0, 1'b1);
    wait_draws(base + 5);
    #1 resetn = 1'b0;
    #1;
    checks += 6;
    if (draw_req   !== 1'b0)  begin errors++; $display("FAIL mid_draw_req: %b vs 0", draw_req); end
    if (turn       !== 1'b0)  begin errors++; $display("FAIL mid_turn: %b vs 0", turn); end
    if (player_sum !== 5'd0)  begin errors++; $display("FAIL mid_player: %0d vs 0", player_sum); end
    if (dealer_sum !== 5'd0)  begin errors++; $display("FAIL mid_dealer: %0d vs 0", dealer_sum); end
    if (busy       !== 1'b0)  begin errors++; $display("FAIL mid_busy: %b vs 0", busy); end
    if (result     !== 2'b00) begin errors++; $display("FAIL mid_result: %b vs 00", result); end
    @(negedge clock) resetn = 1'b1;
    // The undelivered 9 is still next in the stub, so it opens the new round.
    base = draw_cnt;
    load(10); load(8); load(7);
    exp_q.push_back('{5'd17, 5'd17, 2'b11});
    pulse_start();
    settle_player(base + 4);
    press(1'b0, 1'b1);
    wait_idle();
    e = exp_q.pop_front();
    checks += 3;
    if (player_sum !== e.p) begin errors++; $display("FAIL post_player: %0d vs %0d", player_sum, e.p); end
    if (dealer_sum !== e.d) begin errors++; $display("FAIL post_dealer: %0d vs %0d", dealer_sum, e.d); end
    if (result     !== e.r) begin errors++; $display("FAIL post_result: %b vs %b", result, e.r); end
  endtask

  task automatic test_ace();
    int         base;
    exp_t       e;
    logic [4:0] after_deal;
`ifdef ACE_HIGH_EN
    after_deal = 5'd16;
`else
    after_deal = 5'd6;
`endif
    base = draw_cnt;
    load(1); load(10); load(5); load(7); load(9);
    exp_q.push_back('{5'd15, 5'd17, 2'b10});
    pulse_start();
    settle_player(base + 4);
    checks++;
    if (player_sum !== after_deal) begin errors++; $display("FAIL ace_deal: %0d vs %0d", player_sum, after_deal); end
    press(1'b1, 1'b0);
    settle_player(base + 5);
    checks += 2;
    if (player_sum !== 5'd15) begin errors++; $display("FAIL ace_hit: %0d vs 15", player_sum); end
    if (busy !== 1'b1)        begin errors++; $display("FAIL ace_busy: %b vs 1", busy); end
    press(1'b0, 1'b1);
    wait_idle();
    e = exp_q.pop_front();
    checks += 3;
    if (player_sum !== e.p) begin errors++; $display("FAIL ace_player: %0d vs %0d", player_sum, e.p); end
    if (dealer_sum !== e.d) begin errors++; $display("FAIL ace_dealer: %0d vs %0d", dealer_sum, e.d); end
    if (result     !== e.r) begin errors++; $display("FAIL ace_result: %b vs %b", result, e.r); end
  endtask

  task automatic test_single_cycle_req();
    checks++;
    if (dbl != 0) begin errors++; $display("FAIL draw_req_width: %0d multi-cycle pulses vs 0", dbl); end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    test_reset();
    test_push();
    test_player_bust();
    test_dealer_bust();
    test_hit_and_stand();
    test_card_err();
    test_reset_mid_draw();
    test_ace();
    test_single_cycle_req();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
